// File: rtl/pkt_xbar_arb_if.sv
// pkt_xbar_arb_if
// Bundles the crossbar's packet ports so the arbiter and its user share one
// port list.
//   tx0..tx3 : packets offered by processing units 0..3
//              bit [PW+2] valid, [PW+1:PW] destination id, [PW-1:0] payload
//   rx0..rx3 : packets delivered to processing units 0..3
//              bit [PW+2] valid, [PW+1:PW] source id, [PW-1:0] payload
//   ovf      : sticky per-source drop flags
//   busy     : high while any queue holds data or any rx is valid
// Modports: master = processing-unit side, slave = arbiter side.
interface pkt_xbar_arb_if #(
    parameter int PW = 32
);
    logic [PW+2:0] tx0;
    logic [PW+2:0] tx1;
    logic [PW+2:0] tx2;
    logic [PW+2:0] tx3;
    logic [PW+2:0] rx0;
    logic [PW+2:0] rx1;
    logic [PW+2:0] rx2;
    logic [PW+2:0] rx3;
    logic [3:0]    ovf;
    logic          busy;

    modport master (
        output tx0, tx1, tx2, tx3,
        input  rx0, rx1, rx2, rx3, ovf, busy
    );

    modport slave (
        input  tx0, tx1, tx2, tx3,
        output rx0, rx1, rx2, rx3, ovf, busy
    );
endinterface

// File: rtl/pkt_xbar_arb.sv
// pkt_xbar_arb
// Four-source packet crossbar. Each source owns a DEPTH-entry FIFO. One
// queue is granted per cycle by a round-robin arbiter, and the head packet
// is registered onto the rx port named by its destination id, tagged with
// the source id. Packets arriving at a full queue are dropped unless that
// queue is dequeued on the same edge; a drop sets the sticky ovf bit.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : pkt_xbar_arb_if.slave (tx0..tx3 in; rx0..rx3, ovf, busy out)
module pkt_xbar_arb #(
    parameter int PW    = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    pkt_xbar_arb_if.slave  bus
);
    localparam int WW = PW + 3;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    in_valid;
    logic [PW+1:0] in_data [4];
    logic [PW+1:0] head    [4];
    logic [3:0]    nonempty;
    logic [3:0]    drop;
    logic [3:0]    rx_valid;

    logic          grant_valid;
    logic [1:0]    grant_src;
    logic [1:0]    ptr_reg;
    logic [3:0]    ovf_reg;
    logic [WW-1:0] rx_reg [4];

    assign in_valid   = {bus.tx3[WW-1], bus.tx2[WW-1], bus.tx1[WW-1], bus.tx0[WW-1]};
    assign in_data[0] = bus.tx0[PW+1:0];
    assign in_data[1] = bus.tx1[PW+1:0];
    assign in_data[2] = bus.tx2[PW+1:0];
    assign in_data[3] = bus.tx3[PW+1:0];

    // Per-source FIFO
    for (genvar gi = 0; gi < 4; gi++) begin : g_queue
        logic [PW+1:0] q_mem [DEPTH];
        logic [AW-1:0] wr_ptr_reg;
        logic [AW-1:0] rd_ptr_reg;
        logic [CW-1:0] count_reg;
        logic          full;
        logic          deq;
        logic          enq;

        assign full = (count_reg == CW'(DEPTH));
        assign deq  = grant_valid && (grant_src == 2'(gi));
        // A full queue still accepts when its head leaves on the same edge.
        assign enq  = !rst && in_valid[gi] && (!full || deq);

        assign drop[gi]     = !rst && in_valid[gi] && full && !deq;
        assign nonempty[gi] = (count_reg != '0);
        assign head[gi]     = q_mem[rd_ptr_reg];

        always_ff @(posedge clk) begin
            if (enq) begin
                q_mem[wr_ptr_reg] <= in_data[gi];
            end
        end

        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (deq) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                count_reg <= count_reg + CW'(enq) - CW'(deq);
            end
        end

        assign rx_valid[gi] = rx_reg[gi][WW-1];
    end

    // Round-robin: scanning from the far end and overwriting leaves the
    // first non-empty queue at or after the pointer.
    always_comb begin
        logic [1:0] idx;
        idx         = '0;
        grant_valid = 1'b0;
        grant_src   = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_reg + 2'(k);
            if (nonempty[idx]) begin
                grant_valid = 1'b1;
                grant_src   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
            ovf_reg <= '0;
            for (int d = 0; d < 4; d++) begin
                rx_reg[d] <= '0;
            end
        end else begin
            ovf_reg <= ovf_reg | drop;
            for (int d = 0; d < 4; d++) begin
                rx_reg[d] <= '0;
            end
            if (grant_valid) begin
                rx_reg[head[grant_src][PW+1:PW]] <= {1'b1, grant_src, head[grant_src][PW-1:0]};
                ptr_reg <= grant_src + 2'd1;
            end
        end
    end

    assign bus.rx0  = rx_reg[0];
    assign bus.rx1  = rx_reg[1];
    assign bus.rx2  = rx_reg[2];
    assign bus.rx3  = rx_reg[3];
    assign bus.ovf  = ovf_reg;
    assign bus.busy = (|nonempty) || (|rx_valid);
endmodule

// File: tb/tb_pkt_xbar_arb.sv
// tb_pkt_xbar_arb
// Directed table of per-cycle vectors for the crossbar's documented corner
// cases, followed by a randomized run against a queue-based reference model.
module tb_pkt_xbar_arb;
    localparam int PW    = 32;
    localparam int DEPTH = 2;
    localparam int WW    = PW + 3;
    localparam int NV    = 38;
    localparam int NR    = 2000;

    typedef struct packed {
        logic                 rst;
        logic [3:0][WW-1:0]   tx;
        logic [3:0][WW-1:0]   rx;
        logic [3:0]           ovf;
        logic                 busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pkt_xbar_arb_if #(.PW(PW)) bus ();

    pkt_xbar_arb #(.PW(PW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    vec_t vecs [NV];

    function automatic logic [WW-1:0] pk(input logic [1:0] id, input logic [PW-1:0] p);
        return {1'b1, id, p};
    endfunction

    task automatic chk(input string name, input int idx, input logic [WW-1:0] got,
                       input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0][WW-1:0] tx);
        rst     = r;
        bus.tx0 = tx[0];
        bus.tx1 = tx[1];
        bus.tx2 = tx[2];
        bus.tx3 = tx[3];
    endtask

    task automatic check_outs(input int idx, input logic [3:0][WW-1:0] rx,
                              input logic [3:0] ovf, input logic busy);
        chk("rx0", idx, bus.rx0, rx[0]);
        chk("rx1", idx, bus.rx1, rx[1]);
        chk("rx2", idx, bus.rx2, rx[2]);
        chk("rx3", idx, bus.rx3, rx[3]);
        chk("ovf", idx, WW'(bus.ovf), WW'(ovf));
        chk("busy", idx, WW'(bus.busy), WW'(busy));
    endtask

    // Reference model state
    logic [PW+1:0] mq [4][$];
    int            m_ptr;
    logic [3:0]    m_ovf;

    initial begin
        logic [3:0][WW-1:0] tx;
        logic [3:0][WW-1:0] erx;
        logic               r;
        logic               ebusy;
        int                 s;
        logic [PW+1:0]      item;

        drive(1'b1, '0);

        // ---- directed vectors: inputs for a cycle, outputs after its edge ----
        for (int i = 0; i < NV; i++) vecs[i] = '0;
        vecs[0].rst = 1'b1;
        // single packet, latency 2
        vecs[1].tx[1] = pk(2, 32'hDEADBEEF);  vecs[1].busy = 1'b1;
        vecs[2].rx[2] = pk(1, 32'hDEADBEEF);  vecs[2].busy = 1'b1;
        vecs[4].rst = 1'b1;
        // fairness: all four to dest 0
        for (int k = 0; k < 4; k++) begin
            vecs[5].tx[k]   = pk(0, PW'(k));
            vecs[6+k].rx[0] = pk(2'(k), PW'(k));
            vecs[6+k].busy  = 1'b1;
        end
        vecs[5].busy = 1'b1;
        // pointer back at 0: source 0 beats source 3
        vecs[10].tx[0] = pk(1, 32'h50); vecs[10].tx[3] = pk(1, 32'h53); vecs[10].busy = 1'b1;
        vecs[11].rx[1] = pk(0, 32'h50); vecs[11].busy = 1'b1;
        vecs[12].rx[1] = pk(3, 32'h53); vecs[12].busy = 1'b1;
        // resume from pointer 2 with queues 0 and 3 pending
        vecs[13].tx[1] = pk(3, 32'h11); vecs[13].busy = 1'b1;
        vecs[14].tx[0] = pk(2, 32'hA0); vecs[14].tx[3] = pk(2, 32'hA3);
        vecs[14].rx[3] = pk(1, 32'h11); vecs[14].busy = 1'b1;
        vecs[15].rx[2] = pk(3, 32'hA3); vecs[15].busy = 1'b1;
        vecs[16].rx[2] = pk(0, 32'hA0); vecs[16].busy = 1'b1;
        // overflow on queue 0 while other sources are granted
        vecs[18].tx[0] = pk(0, 32'hC0); vecs[18].tx[1] = pk(1, 32'h101);
        vecs[18].tx[2] = pk(2, 32'h102); vecs[18].tx[3] = pk(3, 32'h103); vecs[18].busy = 1'b1;
        vecs[19].tx[0] = pk(0, 32'hC1); vecs[19].rx[1] = pk(1, 32'h101); vecs[19].busy = 1'b1;
        vecs[20].tx[0] = pk(0, 32'hC2); vecs[20].rx[2] = pk(2, 32'h102); vecs[20].busy = 1'b1;
        vecs[21].rx[3] = pk(3, 32'h103); vecs[21].busy = 1'b1;
        vecs[22].rx[0] = pk(0, 32'hC0);  vecs[22].busy = 1'b1;
        vecs[23].rx[0] = pk(0, 32'hC1);  vecs[23].busy = 1'b1;
        for (int i = 20; i <= 24; i++) vecs[i].ovf = 4'b0001;
        vecs[25].rst = 1'b1;
        // full queue 0 dequeued on the same edge a new packet arrives
        vecs[26].tx[1] = pk(2, 32'h201); vecs[26].busy = 1'b1;
        vecs[27].tx[0] = pk(1, 32'hD0); vecs[27].tx[2] = pk(3, 32'h202);
        vecs[27].rx[2] = pk(1, 32'h201); vecs[27].busy = 1'b1;
        vecs[28].tx[0] = pk(1, 32'hD1); vecs[28].rx[3] = pk(2, 32'h202); vecs[28].busy = 1'b1;
        vecs[29].tx[0] = pk(1, 32'hD2); vecs[29].rx[1] = pk(0, 32'hD0);  vecs[29].busy = 1'b1;
        vecs[30].rx[1] = pk(0, 32'hD1); vecs[30].busy = 1'b1;
        vecs[31].rx[1] = pk(0, 32'hD2); vecs[31].busy = 1'b1;
        // reset mid-operation, tx during reset discarded
        vecs[33].tx[0] = pk(2, 32'hE0); vecs[33].tx[1] = pk(2, 32'hE1); vecs[33].busy = 1'b1;
        vecs[34].rst = 1'b1; vecs[34].tx[2] = pk(0, 32'hE2);
        vecs[35].tx[3] = pk(0, 32'hF3); vecs[35].busy = 1'b1;
        vecs[36].rx[0] = pk(3, 32'hF3); vecs[36].busy = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].tx);
            @(posedge clk);
            #1;
            check_outs(i, vecs[i].rx, vecs[i].ovf, vecs[i].busy);
        end

        // ---- randomized run against the reference model ----
        for (int i = 0; i < NR; i++) begin
            r = (i == 0) || ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 4; k++) begin
                tx[k] = {WW{1'b0}};
                tx[k][PW+1:0] = {2'($urandom_range(0, 3)), PW'($urandom)};
                tx[k][WW-1]   = ($urandom_range(0, 99) < 35);
                // invalid words carry junk that must be ignored
                if (!tx[k][WW-1] && $urandom_range(0, 1) == 1) tx[k][PW+1:0] = '1;
            end
            erx = '0;
            if (r) begin
                for (int k = 0; k < 4; k++) mq[k].delete();
                m_ptr = 0;
                m_ovf = '0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    s = (m_ptr + k) % 4;
                    if (mq[s].size() > 0) begin
                        item = mq[s].pop_front();
                        erx[item[PW+1:PW]] = {1'b1, 2'(s), item[PW-1:0]};
                        m_ptr = (s + 1) % 4;
                        break;
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    if (tx[k][WW-1]) begin
                        if (mq[k].size() < DEPTH) mq[k].push_back(tx[k][PW+1:0]);
                        else m_ovf[k] = 1'b1;
                    end
                end
            end
            ebusy = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() > 0 || erx[k][WW-1]) ebusy = 1'b1;
            end
            drive(r, tx);
            @(posedge clk);
            #1;
            check_outs(NV + i, erx, m_ovf, ebusy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
